// File: rtl/skew_fifo_reader_pkg.sv
// Shared definitions for the skewed FIFO read controller: FSM encoding and
// the per-row slice helper for packed multi-row buses.
package skew_fifo_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Base bit index of row 'row' inside a packed ROWS*WIDTH bus.
   function automatic int rowBase(input int row, input int width);
      return row * width;
   endfunction

endpackage

// File: rtl/skew_fifo_reader_row_gate.sv
// One row of the skewed reader: decides whether this row is due at the current
// step, gates its FIFO read on the shared stall, and registers the valid tag.
module skew_row_gate
   import skew_fifo_reader_pkg::*;
#(
   parameter int ROW    = 0,
   parameter int LEN    = 4,
   parameter int WIDTH  = 8,
   parameter int STEP_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  state_e            state_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              stall_i,
   input  logic              fifo_empty_i,
   input  logic [WIDTH-1:0]  fifo_data_i,
   output logic              empty_hit_o,
   output logic              r_en_o,
   output logic              valid_o,
   output logic [WIDTH-1:0]  data_o
);

   localparam logic [STEP_W:0] ROW_HI = (STEP_W+1)'(ROW + LEN);

   logic [STEP_W:0] stepExt;
   logic            aboveLo;
   logic            active;
   logic            running;
   logic            valid_q;

   assign stepExt = {1'b0, step_i};

   // Row 0 starts at step 0, so its lower bound is always met.
   generate
      if (ROW == 0) begin : g_lo_always
         assign aboveLo = 1'b1;
      end else begin : g_lo_cmp
         localparam logic [STEP_W:0] ROW_LO = (STEP_W+1)'(ROW);
         assign aboveLo = (stepExt >= ROW_LO);
      end
   endgenerate

   assign active      = aboveLo && (stepExt < ROW_HI);
   assign running     = (state_i == RUN);
   assign empty_hit_o = running && active && fifo_empty_i;
   assign r_en_o      = running && active && !stall_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= r_en_o;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = valid_q ? fifo_data_i : '0;

endmodule

// File: rtl/skew_fifo_reader.sv
// Drains LEN elements from each of ROWS input FIFOs with a one-cycle-per-row
// diagonal skew, stalling every row together when any due row is empty.
module skew_fifo_reader
   import skew_fifo_reader_pkg::*;
#(
   parameter int ROWS  = 4,
   parameter int WIDTH = 8,
   parameter int LEN   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic [ROWS-1:0]         fifo_empty_i,
   input  logic [ROWS*WIDTH-1:0]   fifo_data_i,
   output logic [ROWS-1:0]         fifo_r_en_o,
   output logic [ROWS*WIDTH-1:0]   array_data_o,
   output logic [ROWS-1:0]         array_valid_o,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam int STEP_W = $clog2(LEN + ROWS);
   localparam logic [STEP_W-1:0] LAST = STEP_W'(LEN + ROWS - 2);

   state_e            state_q;
   logic [STEP_W-1:0] step_q;
   logic              busy_q;
   logic              done_q;
   logic [ROWS-1:0]   emptyHit;
   logic              stall;

   assign stall = |emptyHit;

   generate
      for (genvar r = 0; r < ROWS; r++) begin : g_row
         skew_row_gate #(
            .ROW    (r),
            .LEN    (LEN),
            .WIDTH  (WIDTH),
            .STEP_W (STEP_W)
         ) u_gate (
            .clk          (clk),
            .rst          (rst),
            .state_i      (state_q),
            .step_i       (step_q),
            .stall_i      (stall),
            .fifo_empty_i (fifo_empty_i[r]),
            .fifo_data_i  (fifo_data_i[rowBase(r, WIDTH) +: WIDTH]),
            .empty_hit_o  (emptyHit[r]),
            .r_en_o       (fifo_r_en_o[r]),
            .valid_o      (array_valid_o[r]),
            .data_o       (array_data_o[rowBase(r, WIDTH) +: WIDTH])
         );
      end
   endgenerate

   // A stalled step holds so every row slips by the same amount and the skew survives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         step_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q <= RUN;
                  step_q  <= '0;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               if (!stall) begin
                  if (step_q == LAST) begin
                     state_q <= FLUSH;
                  end else begin
                     step_q <= step_q + STEP_W'(1);
                  end
               end
            end
            FLUSH: begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule
